// File: rtl/video_stream_checker_pkg.sv
// video_checker_pkg: shared state encoding, timing record and stripe colour nibbles
// for video_stream_checker.
package video_checker_pkg;
    localparam int TIMING_W = 12;
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    typedef enum logic [1:0] {SEARCH = ST_SEARCH, MEASURE = ST_MEASURE, TRACK = ST_TRACK} state_t;
    typedef struct packed {
        logic [TIMING_W-1:0] h_active;
        logic [TIMING_W-1:0] h_total;
        logic [TIMING_W-1:0] v_active;
        logic [TIMING_W-1:0] v_total;
    } timing_t;
    localparam logic [3:0] STRIPE_R_LO = 4'h1;
    localparam logic [3:0] STRIPE_G_LO = 4'h3;
    localparam logic [3:0] STRIPE_B_LO = 4'h7;
endpackage

// File: rtl/video_stream_checker_edge_det.sv
// edge_det: rising-edge detector; d is already registered, the delayed copy is
// held here so rise is valid in the same cycle d first reads 1.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 1'b0;
        else q <= d;
    assign rise = d & ~q;
endmodule

// File: rtl/video_stream_checker.sv
// video_stream_checker: measures DVI RX timing and declares lock after stable frames;
// stripe colour checking is built only with VIDEO_STREAM_CHECKER_STRIPE_CHECK_EN.
module video_stream_checker import video_checker_pkg::*; #(
    parameter int CNT_W = TIMING_W,
    parameter int LOCK_FRAMES = 3,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             I_rgb_vs,
    input  logic             I_rgb_hs,
    input  logic             I_rgb_de,
    input  logic [7:0]       I_rgb_r,
    input  logic [7:0]       I_rgb_g,
    input  logic [7:0]       I_rgb_b,
    output logic [CNT_W-1:0] O_h_active,
    output logic [CNT_W-1:0] O_h_total,
    output logic [CNT_W-1:0] O_v_active,
    output logic [CNT_W-1:0] O_v_total,
    output logic             O_frame_done,
    output logic             O_locked,
    output logic [ERR_W-1:0] O_err_count,
    output logic             O_stripe_err
);
    localparam logic [3:0] LOCK = 4'(LOCK_FRAMES);
    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + CNT_W'(1);
    endfunction
    logic vs1, hs1, de1, vs_r, hs_r;
    logic [CNT_W-1:0] hcnt, de_run, line_total, href, vact, vtot;
    logic mism, sat, frame_done, locked;
    logic run_ok, mism_n, sat_n, match;
    logic [3:0] stable, stable_n;
    state_t state, state_n;
    timing_t cur, prev, meas;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {vs1, hs1, de1} <= 3'b000;
        else {vs1, hs1, de1} <= {I_rgb_vs, I_rgb_hs, I_rgb_de};
    edge_det u_vs (.clk(clk), .rst_n(rst_n), .d(vs1), .rise(vs_r));
    edge_det u_hs (.clk(clk), .rst_n(rst_n), .d(hs1), .rise(hs_r));
    // Line accounting is folded into cur so a simultaneous hs rise lands in the closing frame.
    always_comb begin
        run_ok = hs_r && |de_run;
        cur.h_total = hs_r ? inc(hcnt) : line_total;
        cur.h_active = run_ok && href == '0 ? de_run : href;
        cur.v_active = run_ok ? inc(vact) : vact;
        cur.v_total = hs_r ? inc(vtot) : vtot;
        mism_n = mism | (run_ok && |href && de_run != href);
        sat_n = sat | &hcnt | &de_run | &vact | &vtot;
        match = cur == prev && !mism_n && !sat_n && |cur.v_total;
        state_n = !vs_r ? state : state == SEARCH ? MEASURE : TRACK;
        stable_n = !vs_r ? stable : state != TRACK || !match ? 4'd0 : stable == LOCK ? stable : stable + 4'd1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {hcnt, de_run, line_total, href, vact, vtot} <= '0;
            {mism, sat, frame_done, locked} <= 4'b0000;
            stable <= 4'd0;
            state <= SEARCH;
            prev <= '0;
            meas <= '0;
        end else begin
            hcnt <= hs_r ? '0 : inc(hcnt);
            de_run <= hs_r ? '0 : de1 ? inc(de_run) : de_run;
            line_total <= cur.h_total;
            state <= state_n;
            stable <= stable_n;
            frame_done <= vs_r && state != SEARCH;
            locked <= state_n == TRACK && stable_n == LOCK;
            if (vs_r) begin
                {href, vact, vtot} <= '0;
                {mism, sat} <= 2'b00;
                if (state != SEARCH) begin
                    meas <= cur;
                    prev <= cur;
                end
            end else begin
                href <= cur.h_active;
                vact <= cur.v_active;
                vtot <= cur.v_total;
                mism <= mism_n;
                sat <= sat_n;
            end
        end
    assign O_h_active = meas.h_active;
    assign O_h_total = meas.h_total;
    assign O_v_active = meas.v_active;
    assign O_v_total = meas.v_total;
    assign O_frame_done = frame_done;
    assign O_locked = locked;
`ifdef VIDEO_STREAM_CHECKER_STRIPE_CHECK_EN
    logic [7:0] r1, g1, b1;
    logic [6:0] px;
    logic [ERR_W-1:0] err;
    logic de_r, bad, serr;
    edge_det u_de (.clk(clk), .rst_n(rst_n), .d(de1), .rise(de_r));
    // px indexes the pixel currently in s1; stripe index is px/8.
    assign bad = de1 && {r1, g1, b1} != {px[6:3], STRIPE_R_LO, px[6:3], STRIPE_G_LO, px[6:3], STRIPE_B_LO};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {r1, g1, b1} <= '0;
            px <= '0;
            err <= '0;
            serr <= 1'b0;
        end else begin
            {r1, g1, b1} <= {I_rgb_r, I_rgb_g, I_rgb_b};
            px <= !de1 ? 7'd0 : de_r ? 7'd1 : px + 7'd1;
            serr <= bad;
            err <= bad && !(&err) ? err + ERR_W'(1) : err;
        end
    assign O_err_count = err;
    assign O_stripe_err = serr;
`else
    logic rgb_unused;
    assign rgb_unused = ^{I_rgb_r, I_rgb_g, I_rgb_b};
    assign O_err_count = '0;
    assign O_stripe_err = 1'b0;
`endif
endmodule

// File: tb/tb_video_stream_checker.sv
// tb_video_stream_checker: frame-level reference model driven with randomized stripe video;
// expects stripe errors only when VIDEO_STREAM_CHECKER_STRIPE_CHECK_EN is defined.
module tb_video_stream_checker;
    localparam int LOCK = 3;
`ifdef VIDEO_STREAM_CHECKER_STRIPE_CHECK_EN
    localparam int STRIPE = 1;
`else
    localparam int STRIPE = 0;
`endif
    logic clk = 0, rst_n = 0, vs = 0, hs = 0, de = 0;
    logic [7:0] r = 0, g = 0, b = 0;
    logic [11:0] h_active, h_total, v_active, v_total;
    logic frame_done, locked, stripe_err;
    logic [15:0] err_count;
    typedef struct packed {
        logic [11:0] ha, ht, va, vt;
        logic lk;
    } rec_t;
    rec_t obs_q[$], exp_q[$], m_prev;
    bit mis_q[$], m_first = 1;
    int checks = 0, errors = 0, pulses = 0, err_exp = 0, m_stable = 0;

    always #5 clk = ~clk;

    video_stream_checker dut (
        .clk(clk), .rst_n(rst_n), .I_rgb_vs(vs), .I_rgb_hs(hs), .I_rgb_de(de),
        .I_rgb_r(r), .I_rgb_g(g), .I_rgb_b(b),
        .O_h_active(h_active), .O_h_total(h_total), .O_v_active(v_active), .O_v_total(v_total),
        .O_frame_done(frame_done), .O_locked(locked), .O_err_count(err_count), .O_stripe_err(stripe_err)
    );

    task automatic step();
        @(negedge clk);
        if (frame_done) obs_q.push_back({h_active, h_total, v_active, v_total, locked});
        if (stripe_err) pulses++;
    endtask

    // Lock rule: first report after search only seeds prev; then consecutive identical clean frames count up.
    function automatic rec_t model(rec_t e, bit mis);
        bit ok;
        ok = !m_first && {e.ha, e.ht, e.va, e.vt} == {m_prev.ha, m_prev.ht, m_prev.va, m_prev.vt} && !mis && e.vt != 0;
        m_stable = ok ? (m_stable < LOCK ? m_stable + 1 : LOCK) : 0;
        m_first = 0;
        m_prev = e;
        e.lk = m_stable == LOCK;
        return e;
    endfunction

    function automatic void flush_model();
        obs_q.delete(); exp_q.delete(); mis_q.delete();
        m_first = 1; m_stable = 0; err_exp = 0; pulses = 0;
    endfunction

    // One frame: vs rises with the hs of line 0; hs high at clocks 2..5; DE at the end of each active line.
    task automatic drive_frame(int ha, int hb, int va, int vb, int drop = -1, int bad_line = -1,
                               int bad_px = 0, bit zero_g = 0, int stop_line = -1);
        rec_t e;
        bit mis = 0;
        int first = 0;
        for (int l = 0; l < va + vb; l++) begin
            int len;
            len = l < va ? (l == drop ? ha - 1 : ha) : 0;
            if (l == stop_line) return;
            if (len != 0 && first == 0) first = len;
            if (len != 0 && len != first) mis = 1;
            for (int c = 0; c < ha + hb; c++) begin
                int px, ch;
                logic [3:0] s;
                logic [7:0] x;
                px = c - hb;
                s = px[6:3];
                x = 8'($urandom_range(1, 255));
                ch = $urandom_range(0, 2);
                step();
                hs = c >= 2 && c < 6;
                vs = (l == 0 && c >= 2) || l == 1 || (l == 2 && c < 2);
                de = px >= 0 && px < len;
                {r, g, b} = de ? {s, 4'h1, s, 4'h3, s, 4'h7} : 24'($urandom);
                if (de && l == bad_line && px == bad_px) begin
                    if (zero_g) g = 8'h00;
                    else if (ch == 0) r = r ^ x;
                    else if (ch == 1) g = g ^ x;
                    else b = b ^ x;
                    err_exp += STRIPE;
                end
            end
        end
        e = {12'(first), 12'(ha + hb), 12'(va), 12'(va + vb), 1'b0};
        exp_q.push_back(e);
        mis_q.push_back(mis);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) step();
        checks++;
        if ({h_active, h_total, v_active, v_total, frame_done, locked, err_count, stripe_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h/%h/%h/%h fd=%b lk=%b err=%h se=%b, expected all 0",
                h_active, h_total, v_active, v_total, frame_done, locked, err_count, stripe_err);
        end
        rst_n = 1;
        repeat (2) step();
        checks++;
        if ({frame_done, locked, h_total} !== '0) begin
            errors++; $display("FAIL reset_release: fd=%b lk=%b ht=%0d, expected 0", frame_done, locked, h_total);
        end
    endtask

    task automatic test_timing_lock();
        rec_t o, e;
        int n = 0, first_lock = -1;
        repeat (6) drive_frame(32, 16, 8, 4);
        checks++;
        if (obs_q.size() != 5) begin
            errors++; $display("FAIL frame_done_count: got %0d, expected 5", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = model(exp_q.pop_front(), mis_q.pop_front()); n++;
            if (o.lk && first_lock < 0) first_lock = n;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL timing_lock frame %0d: got %0d/%0d/%0d/%0d lk=%b, expected %0d/%0d/%0d/%0d lk=%b",
                    n, o.ha, o.ht, o.va, o.vt, o.lk, e.ha, e.ht, e.va, e.vt, e.lk);
            end
        end
        checks++;
        if (first_lock != LOCK + 1) begin
            errors++; $display("FAIL first_lock_index: got %0d, expected %0d", first_lock, LOCK + 1);
        end
        checks++;
        if (err_count !== 0 || pulses != 0) begin
            errors++; $display("FAIL clean_stripes: err_count=%0d pulses=%0d, expected 0/0", err_count, pulses);
        end
    endtask

    task automatic test_stripe();
        rec_t o, e;
        int p0;
        repeat (3) drive_frame(32, 16, 8, 4, -1, $urandom_range(0, 7), $urandom_range(0, 31));
        p0 = pulses;
        drive_frame(32, 16, 8, 4, -1, $urandom_range(0, 7), 9, 1);
        checks++;
        if (pulses - p0 != STRIPE) begin
            errors++; $display("FAIL stripe_px9_pulse: got %0d pulses, expected %0d", pulses - p0, STRIPE);
        end
        checks++;
        if (err_count !== 16'(err_exp) || pulses != err_exp) begin
            errors++; $display("FAIL stripe_count: err_count=%0d pulses=%0d, expected %0d", err_count, pulses, err_exp);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = model(exp_q.pop_front(), mis_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL stripe_timing: got %0d/%0d/%0d/%0d lk=%b, expected %0d/%0d/%0d/%0d lk=%b",
                    o.ha, o.ht, o.va, o.vt, o.lk, e.ha, e.ht, e.va, e.vt, e.lk);
            end
        end
    endtask

    task automatic test_drop_relock();
        rec_t o, e;
        int low = 0;
        drive_frame(32, 16, 8, 4, $urandom_range(1, 7));
        repeat (4) drive_frame(32, 16, 8, 4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = model(exp_q.pop_front(), mis_q.pop_front());
            low += !o.lk;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL drop_relock: got %0d/%0d/%0d/%0d lk=%b, expected %0d/%0d/%0d/%0d lk=%b",
                    o.ha, o.ht, o.va, o.vt, o.lk, e.ha, e.ht, e.va, e.vt, e.lk);
            end
        end
        checks++;
        if (low != 3 || !locked) begin
            errors++; $display("FAIL drop_unlock_span: low=%0d locked=%b, expected 3/1", low, locked);
        end
    endtask

    task automatic test_resolution_switch();
        rec_t o, e;
        int low = 0;
        repeat (6) drive_frame(40, 16, 8, 4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = model(exp_q.pop_front(), mis_q.pop_front());
            low += !o.lk;
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL res_switch: got %0d/%0d/%0d/%0d lk=%b, expected %0d/%0d/%0d/%0d lk=%b",
                    o.ha, o.ht, o.va, o.vt, o.lk, e.ha, e.ht, e.va, e.vt, e.lk);
            end
        end
        checks++;
        if (low != 3 || h_active !== 12'd40 || h_total !== 12'd56) begin
            errors++; $display("FAIL res_switch_summary: low=%0d ha=%0d ht=%0d, expected 3/40/56", low, h_active, h_total);
        end
    endtask

    task automatic test_random_timing();
        rec_t o, e;
        int ha, hb, va, vb;
        ha = $urandom_range(8, 40); hb = $urandom_range(6, 20);
        va = $urandom_range(2, 10); vb = $urandom_range(3, 6);
        repeat (5) drive_frame(ha, hb, va, vb);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = model(exp_q.pop_front(), mis_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL random_timing: got %0d/%0d/%0d/%0d lk=%b, expected %0d/%0d/%0d/%0d lk=%b",
                    o.ha, o.ht, o.va, o.vt, o.lk, e.ha, e.ht, e.va, e.vt, e.lk);
            end
        end
    endtask

    task automatic test_reset_mid();
        rec_t o, e;
        drive_frame(32, 16, 8, 4, -1, -1, 0, 0, 4);
        rst_n = 0; {vs, hs, de} = 3'b000;
        repeat (3) step();
        checks++;
        if ({h_active, h_total, v_active, v_total, frame_done, locked, err_count, stripe_err} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h/%h/%h/%h fd=%b lk=%b err=%h, expected all 0",
                h_active, h_total, v_active, v_total, frame_done, locked, err_count);
        end
        rst_n = 1;
        flush_model();
        drive_frame(32, 16, 8, 4);
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL mid_reset_first_vs: got %0d frame_done, expected 0", obs_q.size());
        end
        drive_frame(32, 16, 8, 4);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL mid_reset_second_vs: got %0d frame_done, expected 1", obs_q.size());
        end
        drive_frame(32, 16, 8, 4);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = model(exp_q.pop_front(), mis_q.pop_front());
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL mid_reset_frames: got %0d/%0d/%0d/%0d lk=%b, expected %0d/%0d/%0d/%0d lk=%b",
                    o.ha, o.ht, o.va, o.vt, o.lk, e.ha, e.ht, e.va, e.vt, e.lk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing_lock();
        test_stripe();
        test_drop_relock();
        test_resolution_switch();
        test_random_timing();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
